// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the parametrised multi-port register file.
package regfile_pkg;

  localparam int DEF_XLEN  = 64;
  localparam int DEF_NREGS = 32;
  localparam int ZERO_IDX  = 0;

  // Address width for a register count; never narrower than one bit.
  function automatic int addr_width(input int nregs);
    return (nregs > 1) ? $clog2(nregs) : 1;
  endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One read port: storage mux, zero/range masking and write-bypass priority chain.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int XLEN     = DEF_XLEN,
  parameter int NREGS    = DEF_NREGS,
  parameter int NWRITE   = 1,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1,
  parameter int AW       = addr_width(DEF_NREGS)
) (
  input  logic                   reset,
  input  logic [AW-1:0]          addr,
  input  logic [NREGS*XLEN-1:0]  store,
  input  logic [NWRITE-1:0]      wr_ok,
  input  logic [NWRITE*AW-1:0]   rd,
  input  logic [NWRITE*XLEN-1:0] wdata,
  output logic [XLEN-1:0]        data
);

  logic [XLEN-1:0] stored_s;
  logic [XLEN-1:0] byp_data_s;
  logic            byp_hit_s;
  logic            is_zero_s;
  logic            out_range_s;

  // Stored-word select; wr_ok already carries the write qualification rules.
  always_comb begin
    stored_s   = '0;
    byp_data_s = '0;
    byp_hit_s  = 1'b0;
    for (int i = 0; i < NREGS; i++) begin
      stored_s = stored_s | ({XLEN{32'(addr) == i}} & store[i*XLEN +: XLEN]);
    end
    for (int w = 0; w < NWRITE; w++) begin
      // Ascending scan so the highest-indexed matching port is the one left standing.
      byp_data_s = (wr_ok[w] && (rd[w*AW +: AW] == addr)) ? wdata[w*XLEN +: XLEN] : byp_data_s;
      byp_hit_s  = byp_hit_s | (wr_ok[w] && (rd[w*AW +: AW] == addr));
    end
  end

  assign is_zero_s   = (ZERO_REG != 0) && (addr == AW'(ZERO_IDX));
  assign out_range_s = (32'(addr) >= 32'(NREGS));

  // Read priority: reset, zero register, out of range, bypass, storage.
  always_comb begin
    if (reset) begin
      data = '0;
    end else if (is_zero_s || out_range_s) begin
      data = '0;
    end else if ((BYPASS != 0) && byp_hit_s) begin
      data = byp_data_s;
    end else begin
      data = stored_s;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port integer register file: flop storage, write decode with
// higher-port-wins collision resolution, and NREAD combinational read ports.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN     = DEF_XLEN,
  parameter int NREGS    = DEF_NREGS,
  parameter int NREAD    = 2,
  parameter int NWRITE   = 1,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1,
  localparam int AW      = addr_width(NREGS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREAD*AW-1:0]    rs,
  output logic [NREAD*XLEN-1:0]  readData,
  input  logic [NWRITE*AW-1:0]   rd,
  input  logic [NWRITE*XLEN-1:0] WriteData,
  input  logic [NWRITE-1:0]      regWrite
);

  logic [XLEN-1:0]       regs_r [NREGS];
  logic [NREGS*XLEN-1:0] store_s;
  logic [NWRITE-1:0]     wr_ok_s;

  // A write qualifies only when enabled, out of reset, in range and not aimed at x0.
  always_comb begin
    wr_ok_s = '0;
    for (int w = 0; w < NWRITE; w++) begin
      wr_ok_s[w] = regWrite[w] && !reset
                && (32'(rd[w*AW +: AW]) < 32'(NREGS))
                && !((ZERO_REG != 0) && (rd[w*AW +: AW] == AW'(ZERO_IDX)));
    end
  end

  // Storage update; later ports overwrite earlier ones on the same target.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_r[i] <= '0;
      end
    end else begin
      for (int w = 0; w < NWRITE; w++) begin
        if (wr_ok_s[w]) begin
          regs_r[rd[w*AW +: AW]] <= WriteData[w*XLEN +: XLEN];
        end
      end
    end
  end

  for (genvar g = 0; g < NREGS; g++) begin : g_flat
    assign store_s[g*XLEN +: XLEN] = regs_r[g];
  end

  for (genvar r = 0; r < NREAD; r++) begin : g_read
    regfile_read_port #(
      .XLEN     (XLEN),
      .NREGS    (NREGS),
      .NWRITE   (NWRITE),
      .BYPASS   (BYPASS),
      .ZERO_REG (ZERO_REG),
      .AW       (AW)
    ) u_read_port (
      .reset (reset),
      .addr  (rs[r*AW +: AW]),
      .store (store_s),
      .wr_ok (wr_ok_s),
      .rd    (rd),
      .wdata (WriteData),
      .data  (readData[r*XLEN +: XLEN])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench: two regfile_mp configurations driven by shared stimulus
// and compared against an architectural register-array model.
module tb_regfile_mp;

  logic         clk;
  logic         reset;
  logic [19:0]  rs;
  logic [9:0]   rd;
  logic [127:0] wdata;
  logic [1:0]   we;
  logic [255:0] rda;
  logic [255:0] rdb;

  logic [63:0] ma [32];
  logic [63:0] mb [32];

  int checks;
  int failures;

  // A: 24 regs, bypass on, hardwired x0.  B: 32 regs, no bypass, x0 ordinary.
  regfile_mp #(.XLEN(64), .NREGS(24), .NREAD(4), .NWRITE(2), .BYPASS(1), .ZERO_REG(1)) dut_a (
    .clk(clk), .reset(reset), .rs(rs), .readData(rda), .rd(rd), .WriteData(wdata), .regWrite(we));

  regfile_mp #(.XLEN(64), .NREGS(32), .NREAD(4), .NWRITE(2), .BYPASS(0), .ZERO_REG(0)) dut_b (
    .clk(clk), .reset(reset), .rs(rs), .readData(rdb), .rd(rd), .WriteData(wdata), .regWrite(we));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] exp_read(input bit is_a, input int addr);
    logic [63:0] v;
    int nregs;
    nregs = is_a ? 24 : 32;
    if (reset) return 64'd0;
    if (is_a && addr == 0) return 64'd0;
    if (addr >= nregs) return 64'd0;
    v = is_a ? ma[addr] : mb[addr];
    if (is_a) begin
      for (int w = 0; w < 2; w++) begin
        if (we[w] && int'(rd[w*5 +: 5]) == addr) v = wdata[w*64 +: 64];
      end
    end
    return v;
  endfunction

  task automatic clear_models();
    for (int i = 0; i < 32; i++) begin
      ma[i] = 64'd0;
      mb[i] = 64'd0;
    end
  endtask

  task automatic step();
    int a;
    @(posedge clk);
    if (!reset) begin
      for (int w = 0; w < 2; w++) begin
        a = int'(rd[w*5 +: 5]);
        if (we[w]) begin
          if (a < 24 && a != 0) ma[a] = wdata[w*64 +: 64];
          mb[a] = wdata[w*64 +: 64];
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; we = 2'b00; rd = 10'd0; wdata = 128'd0; rs = {5'd3, 5'd2, 5'd1, 5'd0};
    clear_models();
    step(); step();
    for (int r = 0; r < 4; r++) begin
      checks++;
      if (rda[r*64 +: 64] !== 64'd0 || rdb[r*64 +: 64] !== 64'd0) begin
        failures++;
        $display("FAIL reset_read port%0d a=%h b=%h want 0", r, rda[r*64 +: 64], rdb[r*64 +: 64]);
      end
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_async_reset();
    we = 2'b11; rd = {5'd9, 5'd5}; wdata = {64'h1, 64'hDEAD};
    step();
    we = 2'b00; rs = {5'd0, 5'd0, 5'd9, 5'd5};
    #1;
    checks++;
    if (rda[63:0] !== 64'hDEAD || rdb[63:0] !== 64'hDEAD) begin
      failures++; $display("FAIL load_x5 a=%h b=%h want dead", rda[63:0], rdb[63:0]);
    end
    checks++;
    if (rda[127:64] !== 64'h1 || rdb[127:64] !== 64'h1) begin
      failures++; $display("FAIL load_x9 a=%h b=%h want 1", rda[127:64], rdb[127:64]);
    end
    #2;
    reset = 1'b1;
    clear_models();
    #1;
    checks++;
    if (rda[127:0] !== 128'd0 || rdb[127:0] !== 128'd0) begin
      failures++; $display("FAIL async_reset_midcycle a=%h b=%h want 0", rda[127:0], rdb[127:0]);
    end
    step();
    reset = 1'b0;
    #1;
    checks++;
    if (rda[127:0] !== 128'd0 || rdb[127:0] !== 128'd0) begin
      failures++; $display("FAIL after_reset_release a=%h b=%h want 0", rda[127:0], rdb[127:0]);
    end
  endtask

  task automatic test_zero_reg();
    we = 2'b01; rd = {5'd0, 5'd0}; wdata = {64'd0, 64'hFFFF_FFFF_FFFF_FFFF}; rs = 20'd0;
    #1;
    checks++;
    if (rda[63:0] !== 64'd0 || rdb[63:0] !== 64'd0) begin
      failures++; $display("FAIL zero_same_cycle a=%h b=%h want 0", rda[63:0], rdb[63:0]);
    end
    step();
    we = 2'b00;
    #1;
    checks++;
    if (rda[63:0] !== 64'd0) begin
      failures++; $display("FAIL zero_reg_a got=%h want 0", rda[63:0]);
    end
    checks++;
    if (rdb[63:0] !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      failures++; $display("FAIL x0_ordinary_b got=%h want ffffffffffffffff", rdb[63:0]);
    end
  endtask

  task automatic test_bypass();
    we = 2'b01; rd = {5'd0, 5'd9}; wdata = {64'd0, 64'h5};
    step();
    wdata = {64'd0, 64'h1}; rs = {15'd0, 5'd9};
    #1;
    checks++;
    if (rda[63:0] !== 64'h1) begin
      failures++; $display("FAIL bypass_a got=%h want 1", rda[63:0]);
    end
    checks++;
    if (rdb[63:0] !== 64'h5) begin
      failures++; $display("FAIL no_bypass_b got=%h want 5", rdb[63:0]);
    end
    step();
    we = 2'b00;
    #1;
    checks++;
    if (rda[63:0] !== 64'h1 || rdb[63:0] !== 64'h1) begin
      failures++; $display("FAIL after_write_x9 a=%h b=%h want 1", rda[63:0], rdb[63:0]);
    end
  endtask

  task automatic test_collision();
    we = 2'b11; rd = {5'd11, 5'd11}; wdata = {64'hBB, 64'hAA}; rs = {15'd0, 5'd11};
    #1;
    checks++;
    if (rda[63:0] !== 64'hBB) begin
      failures++; $display("FAIL collision_bypass got=%h want bb", rda[63:0]);
    end
    step();
    we = 2'b00;
    #1;
    checks++;
    if (rda[63:0] !== 64'hBB || rdb[63:0] !== 64'hBB) begin
      failures++; $display("FAIL collision_store a=%h b=%h want bb", rda[63:0], rdb[63:0]);
    end
  endtask

  task automatic test_multi_read();
    we = 2'b11; rd = {5'd2, 5'd1}; wdata = {64'd20, 64'd10};
    step();
    rd = {5'd4, 5'd3}; wdata = {64'd40, 64'd30};
    step();
    we = 2'b00; rs = {5'd4, 5'd3, 5'd2, 5'd1};
    #1;
    for (int r = 0; r < 4; r++) begin
      checks++;
      if (rda[r*64 +: 64] !== 64'(10 * (r + 1)) || rdb[r*64 +: 64] !== 64'(10 * (r + 1))) begin
        failures++;
        $display("FAIL multi_read port%0d a=%0d b=%0d want %0d", r, rda[r*64 +: 64], rdb[r*64 +: 64], 10 * (r + 1));
      end
    end
  endtask

  task automatic test_out_of_range();
    logic [19:0] addrs;
    we = 2'b01; rd = {5'd0, 5'd30}; wdata = {64'd0, 64'h1234}; rs = {15'd0, 5'd30};
    #1;
    checks++;
    if (rda[63:0] !== 64'd0) begin
      failures++; $display("FAIL range_bypass_a got=%h want 0", rda[63:0]);
    end
    step();
    we = 2'b00;
    #1;
    checks++;
    if (rda[63:0] !== 64'd0 || rdb[63:0] !== 64'h1234) begin
      failures++; $display("FAIL range_read a=%h want 0 b=%h want 1234", rda[63:0], rdb[63:0]);
    end
    for (int base = 0; base < 24; base += 4) begin
      addrs = {5'(base + 3), 5'(base + 2), 5'(base + 1), 5'(base)};
      rs = addrs;
      #1;
      for (int r = 0; r < 4; r++) begin
        checks++;
        if (rda[r*64 +: 64] !== exp_read(1'b1, base + r)) begin
          failures++;
          $display("FAIL range_no_change x%0d got=%h want %h", base + r, rda[r*64 +: 64], exp_read(1'b1, base + r));
        end
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      we    = 2'($urandom_range(0, 3));
      rd    = 10'($urandom);
      wdata = {$urandom, $urandom, $urandom, $urandom};
      rs    = 20'($urandom);
      if ($urandom_range(0, 49) == 0) begin
        #2;
        reset = 1'b1;
        clear_models();
      end
      #1;
      for (int r = 0; r < 4; r++) begin
        checks++;
        if (rda[r*64 +: 64] !== exp_read(1'b1, int'(rs[r*5 +: 5]))) begin
          failures++;
          $display("FAIL random_a n=%0d port%0d got=%h want %h", n, r, rda[r*64 +: 64], exp_read(1'b1, int'(rs[r*5 +: 5])));
        end
        checks++;
        if (rdb[r*64 +: 64] !== exp_read(1'b0, int'(rs[r*5 +: 5]))) begin
          failures++;
          $display("FAIL random_b n=%0d port%0d got=%h want %h", n, r, rdb[r*64 +: 64], exp_read(1'b0, int'(rs[r*5 +: 5])));
        end
      end
      step();
      reset = 1'b0;
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_async_reset();
    test_zero_reg();
    test_bypass();
    test_collision();
    test_multi_read();
    test_out_of_range();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
